high_score_tracker: RTL and testbench

Post-game leaderboard stage that sits downstream of the per-user score RAM controller. On each end-of-game pulse (the game's score-reset strobe) it snapshots the six per-user stored scores and scans them one per clock. It publishes the best score and the holder's user index to the hex decoders. It raises a timed "new record" flag whenever the best score rises.

---
 rtl/high_score_tracker.sv | 125 ++++++++++++
 tb/tb_high_score_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/high_score_tracker.sv
// -----------------------------------------------------------------------------
// high_score_tracker
//
// Post-game leaderboard stage. On an end-of-game strobe it snapshots the six
// per-user scores, scans them one per clock, and then publishes the best score
// and the index of the user who holds it. A timed "new record" flag is raised
// whenever the published best score goes up.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   scan_req     single-cycle start strobe (accepted only in IDLE)
//   score0..5    stored 8-bit unsigned score of users 0..5
//   busy         high while a scan or commit is pending (state != IDLE)
//   done         one-cycle pulse when results are committed
//   best_score   highest score found by the last completed scan
//   best_user    index 0..5 of the holder, 3'd7 = no holder
//   new_record   high for HOLD_CYCLES cycles after a commit that raised
//                best_score
// -----------------------------------------------------------------------------
module high_score_tracker #(
    parameter int NUM_USERS   = 6,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_req,
    input  logic [7:0] score0,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    input  logic [7:0] score3,
    input  logic [7:0] score4,
    input  logic [7:0] score5,
    output logic       busy,
    output logic       done,
    output logic [7:0] best_score,
    output logic [2:0] best_user,
    output logic       new_record
);

    localparam int         CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_IDX  = 3'(NUM_USERS - 1);
    localparam logic [2:0] NO_USER   = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_snap [0:NUM_USERS-1];
    logic [2:0]       r_idx;
    logic [7:0]       r_run_max;
    logic [2:0]       r_run_user;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [7:0]       w_cur;

    assign w_cur = r_snap[r_idx];
    assign busy  = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_run_max  <= 8'd0;
            r_run_user <= NO_USER;
            r_hold_cnt <= '0;
            for (int i = 0; i < NUM_USERS; i++) r_snap[i] <= 8'd0;
            best_score <= 8'd0;
            best_user  <= NO_USER;
            done       <= 1'b0;
            new_record <= 1'b0;
        end else begin
            done <= 1'b0;

            // Hold timer; a commit below may override this with a reload.
            if (new_record) begin
                if (r_hold_cnt == '0) new_record <= 1'b0;
                else                  r_hold_cnt <= r_hold_cnt - CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (scan_req) begin
                        r_snap[0]  <= score0;
                        r_snap[1]  <= score1;
                        r_snap[2]  <= score2;
                        r_snap[3]  <= score3;
                        r_snap[4]  <= score4;
                        r_snap[5]  <= score5;
                        r_idx      <= 3'd0;
                        r_run_max  <= 8'd0;
                        r_run_user <= NO_USER;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare: on ties the lowest index keeps the lead,
                    // and an all-zero snapshot leaves the holder at NO_USER.
                    if (w_cur > r_run_max) begin
                        r_run_max  <= w_cur;
                        r_run_user <= r_idx;
                    end
                    if (r_idx == LAST_IDX) r_state <= COMMIT;
                    else                   r_idx   <= r_idx + 3'd1;
                end
                COMMIT: begin
                    // Results always overwrite, even when lower than before.
                    best_score <= r_run_max;
                    best_user  <= r_run_user;
                    done       <= 1'b1;
                    if (r_run_max > best_score) begin
                        new_record <= 1'b1;
                        r_hold_cnt <= HOLD_LOAD;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_high_score_tracker.sv
module tb_high_score_tracker;

    localparam int HOLD = 4;

    typedef struct packed {
        logic [7:0] sc;
        logic [2:0] usr;
        logic       nr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_req;
    logic [7:0] sc [6];
    logic       busy, done, new_record;
    logic [7:0] best_score;
    logic [2:0] best_user;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic [7:0] m_best = 8'd0;
    exp_t sb_q [$];

    high_score_tracker #(.NUM_USERS(6), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .scan_req(scan_req),
        .score0(sc[0]), .score1(sc[1]), .score2(sc[2]),
        .score3(sc[3]), .score4(sc[4]), .score5(sc[5]),
        .busy(busy), .done(done), .best_score(best_score),
        .best_user(best_user), .new_record(new_record)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_sc(input logic [7:0] a, b, c, d, e, f);
        sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d; sc[4] = e; sc[5] = f;
    endtask

    // Reference: strict max, lowest index on ties, 7 when nothing beats 0.
    task automatic push_expected();
        exp_t x;
        x.sc  = 8'd0;
        x.usr = 3'd7;
        for (int i = 0; i < 6; i++)
            if (sc[i] > x.sc) begin x.sc = sc[i]; x.usr = 3'(i); end
        x.nr   = (x.sc > m_best);
        m_best = x.sc;
        sb_q.push_back(x);
    endtask

    // Full scan from E0 to E8; optional extra strobes at E3 and E7.
    task automatic do_scan(input string name, input bit poke3, input bit poke7);
        exp_t x;
        int   d0;
        d0 = done_cnt;
        scan_req = 1'b1;
        push_expected();
        tick();                                 // E0
        scan_req = 1'b0;
        for (int i = 0; i < 6; i++) sc[i] = 8'hFF;  // must not reach the scan
        chk({name, "_busy_E0"}, busy, 1);
        for (int e = 1; e <= 7; e++) begin
            if ((e == 3 && poke3) || (e == 7 && poke7)) scan_req = 1'b1;
            tick();
            scan_req = 1'b0;
            if (e < 7) begin
                chk($sformatf("%s_busy_E%0d", name, e), busy, 1);
                chk($sformatf("%s_done_E%0d", name, e), done, 0);
            end
        end
        chk({name, "_busy_E7"}, busy, 0);
        chk({name, "_done_E7"}, done, 1);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            x = sb_q.pop_front();
            chk({name, "_best_score"}, best_score, x.sc);
            chk({name, "_best_user"}, best_user, x.usr);
            chk({name, "_new_record"}, new_record, x.nr);
        end
        tick();                                 // E8
        chk({name, "_done_E8"}, done, 0);
        chk({name, "_busy_E8"}, busy, 0);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic wait_hold();
        repeat (HOLD + 3) tick();
    endtask

    initial begin
        int nr_len;
        int d_save;
        rst = 1'b1;
        scan_req = 1'b0;
        set_sc(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_best_score", best_score, 0);
        chk("rst_best_user", best_user, 7);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_new_record", new_record, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_user", best_user, 7);

        // Tie 40/40: user 1 wins; new_record lasts HOLD cycles from E7.
        set_sc(10, 40, 25, 40, 5, 0);
        do_scan("tie", 0, 0);
        nr_len = 2;                             // sampled high after E7 and E8
        for (int k = 0; k < 10 && new_record === 1'b1; k++) begin
            tick();
            if (new_record === 1'b1) nr_len++;
        end
        chk("nr_len", nr_len, HOLD);
        wait_hold();

        // All zero: no holder, no record.
        set_sc(0, 0, 0, 0, 0, 0);
        do_scan("zero", 0, 0);
        tick();
        chk("zero_nr_stays", new_record, 0);
        wait_hold();

        // Max 40 then a lower max 30: overwrite without record.
        set_sc(3, 40, 40, 7, 40, 1);
        do_scan("hi40", 0, 0);
        wait_hold();
        set_sc(30, 12, 30, 0, 0, 29);
        do_scan("lo30", 0, 0);
        wait_hold();

        // Strobes at E3 and E7 are dropped.
        set_sc(50, 60, 70, 80, 90, 100);
        do_scan("poke", 1, 1);
        repeat (10) tick();
        chk("poke_no_extra_scan", busy, 0);
        wait_hold();

        // Reset at E4 of a scan holding 99.
        d_save = done_cnt;
        set_sc(99, 1, 2, 3, 4, 5);
        scan_req = 1'b1;
        tick();                                 // E0
        scan_req = 1'b0;
        tick(); tick(); tick();                 // E1..E3
        rst = 1'b1;
        #1;
        chk("mid_rst_best_score", best_score, 0);
        chk("mid_rst_best_user", best_user, 7);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_nr", new_record, 0);
        tick(); tick();
        rst = 1'b0;
        m_best = 8'd0;
        repeat (8) tick();
        chk("mid_rst_no_done", done_cnt - d_save, 0);
        chk("mid_rst_idle", busy, 0);
        set_sc(5, 6, 7, 8, 9, 4);
        do_scan("after_rst", 0, 0);
        wait_hold();

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
